// File: rtl/mips_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_defs_pkg - opcode/funct encodings and load-type decode shared   |
// | by the write-back stage.                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mips_defs_pkg;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_LB    = 6'h20;
  localparam logic [5:0] c_OP_LBU   = 6'h24;
  localparam logic [5:0] c_OP_LH    = 6'h21;
  localparam logic [5:0] c_OP_LHU   = 6'h25;

  localparam logic [5:0] c_FN_ADDU  = 6'h21;
  localparam logic [5:0] c_FN_SUBU  = 6'h23;
  localparam logic [5:0] c_FN_JR    = 6'h08;
  localparam logic [5:0] c_FN_JALR  = 6'h09;

  localparam logic [4:0] c_REG_RA   = 5'd31;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_B    = 3'd2,
    LD_BU   = 3'd3,
    LD_H    = 3'd4,
    LD_HU   = 3'd5
  } load_op_e;

  function automatic load_op_e load_op_of(input logic [5:0] opcode);
    load_op_e r;
    r = LD_NONE;
    case (opcode)
      c_OP_LW:  r = LD_W;
      c_OP_LB:  r = LD_B;
      c_OP_LBU: r = LD_BU;
      c_OP_LH:  r = LD_H;
      c_OP_LHU: r = LD_HU;
      default:  r = LD_NONE;
    endcase
    return r;
  endfunction

endpackage : mips_defs_pkg
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_ext - selects and extends the byte/half/word of a loaded data   |
// | memory word according to the load type and low address bits.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_ext
  import mips_defs_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  load_op_e    op,
  output logic [31:0] value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lane selection: address 0 is the least significant lane.
  always_comb begin
    w_byte = 8'd0;
    case (addr)
      2'd0: w_byte = word[7:0];
      2'd1: w_byte = word[15:8];
      2'd2: w_byte = word[23:16];
      2'd3: w_byte = word[31:24];
      default: w_byte = 8'd0;
    endcase
  end

  assign w_half = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    value = 32'd0;
    case (op)
      LD_W:    value = word;
      LD_B:    value = {{24{w_byte[7]}}, w_byte};
      LD_BU:   value = {24'd0, w_byte};
      LD_H:    value = {{16{w_half[15]}}, w_half};
      LD_HU:   value = {16'd0, w_half};
      default: value = 32'd0;
    endcase
  end

endmodule : load_ext
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_stage - MIPS write-back pipeline stage: W registers, GRF write    |
// | destination/data/enable, optional retired-instruction counter        |
// | (enabled by defining WB_RETIRE_CNT_EN).                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_stage
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic [31:0] alu_out,
  input  logic [31:0] dmout,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic        we,
  output logic [31:0] retire_cnt
);

  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic [31:0] r_ao;
  logic [31:0] r_dr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir  <= 32'd0;
      r_pc  <= PC_RESET;
      r_pc4 <= PC_RESET + 32'd4;
      r_ao  <= 32'd0;
      r_dr  <= 32'd0;
    end else begin
      r_ir  <= instr;
      r_pc  <= pc;
      r_pc4 <= pc4;
      r_ao  <= alu_out;
      r_dr  <= dmout;
    end
  end

  assign instr_out = r_ir;
  assign pc_out    = r_pc;
  assign pc4_out   = r_pc4;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [4:0] w_dest;
  logic       w_writes;
  logic       w_link;

  assign w_op    = r_ir[31:26];
  assign w_funct = r_ir[5:0];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];

  // Anything not listed (jr, sw, beq, unknown) falls through as non-writing.
  always_comb begin
    w_dest   = 5'd0;
    w_writes = 1'b0;
    w_link   = 1'b0;
    case (w_op)
      c_OP_RTYPE: begin
        case (w_funct)
          c_FN_ADDU, c_FN_SUBU: begin
            w_dest   = w_rd;
            w_writes = 1'b1;
          end
          c_FN_JALR: begin
            w_dest   = w_rd;
            w_writes = 1'b1;
            w_link   = 1'b1;
          end
          default: ;
        endcase
      end
      c_OP_ORI, c_OP_LUI, c_OP_LW, c_OP_LB, c_OP_LBU, c_OP_LH, c_OP_LHU: begin
        w_dest   = w_rt;
        w_writes = 1'b1;
      end
      c_OP_JAL: begin
        w_dest   = c_REG_RA;
        w_writes = 1'b1;
        w_link   = 1'b1;
      end
      default: ;
    endcase
  end

  load_op_e    w_load_op;
  logic [31:0] w_load_val;

  assign w_load_op = load_op_of(w_op);

  load_ext u_load_ext (
    .word  (r_dr),
    .addr  (r_ao[1:0]),
    .op    (w_load_op),
    .value (w_load_val)
  );

  assign wa = w_dest;
  assign we = w_writes && (w_dest != 5'd0);

  always_comb begin
    wd = r_ao;
    if (w_link) begin
      wd = r_pc4 + 32'd4;
    end else if (w_load_op != LD_NONE) begin
      wd = w_load_val;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_cnt <= 32'd0;
    end else if (instr != 32'd0) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule : wb_stage
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, which is the reset value of the latched PC.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port instr  input  32  instruction leaving the memory stage.
REQ-005 SHALL have ports pc / pc4  input  32 each  memory-stage PC and PC+4.
REQ-006 SHALL have port alu_out  input  32  memory-stage ALU result / address.
REQ-007 SHALL have port dmout  input  32  raw data-memory word read this cycle.
REQ-008 SHALL have ports instr_out / pc_out / pc4_out  output  32 each  latched W copies.
REQ-009 SHALL have port wa  output  5  GRF write address.
REQ-010 SHALL have port wd  output  32  GRF write data.
REQ-011 SHALL have port we  output  1  GRF write enable.
REQ-012 SHALL have port retire_cnt  output  32  retired-instruction count (see Configuration).

Function
REQ-013 SHALL latch instr, pc, pc4, alu_out and dmout into IR_W, PC_W, PC4_W, AO_W and DR_W on every rising clk edge when reset=1, with no stall or enable.
REQ-014 SHALL drive instr_out, pc_out and pc4_out directly from IR_W, PC_W and PC4_W, giving exactly one cycle of latency.
REQ-015 SHALL set wa to: rd for R-type addu/subu/jalr; rt for ori/lui/lw/lb/lbu/lh/lhu; 5'd31 for jal; 0 for all other opcodes.
REQ-016 SHALL drive we=1 only when the instruction writes and wa!=0, so writes to $0 are always suppressed.
REQ-017 SHALL select wd as follows: jal/jalr -> PC4_W+4; loads -> the extended DR_W; all else -> AO_W.
REQ-018 SHALL extend lw as the full word.
REQ-019 SHALL extend lb/lbu from byte AO_W[1:0] (0 -> bits 7:0, little-endian), sign- or zero-extended.
REQ-020 SHALL extend lh/lhu from half AO_W[1] (0 -> bits 15:0), sign- or zero-extended.
REQ-021 SHALL use the opcode/funct encodings addu 0/21, subu 0/23, jr 0/08, jalr 0/09, ori 0D, lui 0F, lw 23, sw 2B, beq 04, jal 03, lb 20, lbu 24, lh 21, lhu 25 (all hex).
REQ-022 SHALL treat any unknown encoding as a non-writing instruction (we=0).
REQ-023 SHALL make wa, wd and we purely combinational from the W registers, so they are valid in the same cycle for forwarding to the M and E stages.

Reset
REQ-024 SHALL, while reset=0, immediately clear IR_W, AO_W and DR_W to 0, set PC_W=PC_RESET and PC4_W=PC_RESET+4, and clear retire_cnt to 0, independent of clk.
REQ-025 SHALL give the post-reset IR_W=0 the meaning of a nop: we=0 and wa=0.
REQ-026 SHALL, on reset deassertion mid-stream, accept the first input on the next rising edge, with no partial state retained.

Configuration
REQ-027 SHALL, when WB_RETIRE_CNT_EN is defined, increment retire_cnt by 1 on each rising edge at which the incoming instr is nonzero, wrapping 32'hFFFF_FFFF to 0.
REQ-028 SHALL, when WB_RETIRE_CNT_EN is undefined, tie retire_cnt to 0 and synthesize no counter flops.

Structure
REQ-029 SHALL take the opcode/funct localparams and the 5'd31 link-register constant from shared package mips_defs_pkg.
REQ-030 SHALL place the load extension in one combinational sub-module, load_ext (inputs: word, addr[1:0], op; output: 32-bit value).
REQ-031 SHALL keep the pipeline registers, write-destination decode, wd mux and counter in wb_stage.

Verification
REQ-032 SHALL verify lb: instr=lb $5,0($0), alu_out=32'h2, dmout=32'h80FF_1234 -> next cycle wa=5, we=1, wd=32'hFFFF_FFFF.
REQ-033 SHALL verify lbu/lhu: same dmout with lbu -> wd=32'h0000_00FF; with lhu and alu_out=32'h2 -> wd=32'h0000_80FF.
REQ-034 SHALL verify jal: jal at pc=32'h3008, pc4=32'h300C -> wa=31, we=1, wd=32'h3010.
REQ-035 SHALL verify the $0 guard: addu $0,$1,$2 -> we=0; sw and beq -> we=0 and wa=0.
REQ-036 SHALL verify asynchronous reset: drop reset mid-cycle -> outputs clear at once, pc_out=32'h3000, pc4_out=32'h3004, retire_cnt=0, with no clk edge needed.
REQ-037 SHALL verify the counter (with WB_RETIRE_CNT_EN): preload retire_cnt to 32'hFFFF_FFFE and feed 3 nonzero instrs -> FFFF_FFFF, 0, 1; with the macro undefined -> retire_cnt stays 0.
